// File: rtl/multi_edge_det_pkg.sv
// rtl/multi_edge_det_pkg.sv - shared types and defaults for the multi-channel edge detector
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/multi_edge_det_if.sv
// rtl/multi_edge_det_if.sv - channel-vector bus between the edge detector and its user
interface multi_edge_det_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    logic [NCH-1:0]            sig_i;
    logic [NCH-1:0][1:0]       mode_i;
    logic [NCH-1:0]            clr_i;
    logic [NCH-1:0]            det_o;
    logic [NCH-1:0]            sticky_o;
    logic [NCH-1:0][CNT_W-1:0] cnt_o;
    logic                      any_o;

    modport master (
        output sig_i, mode_i, clr_i,
        input  det_o, sticky_o, cnt_o, any_o
    );

    modport slave (
        input  sig_i, mode_i, clr_i,
        output det_o, sticky_o, cnt_o, any_o
    );
endinterface

// File: rtl/multi_edge_det_chan.sv
// rtl/multi_edge_det_chan.sv - one edge-detect channel; glitch filter under EDGE_DET_GLITCH_FILTER_EN
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = 8,
    parameter int FILT_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sig,
    input  edge_mode_e       i_mode,
    input  logic             i_clr,
    output logic             o_det,
    output logic             o_sticky,
    output logic [CNT_W-1:0] o_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_det;
    logic                   r_sticky;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_s;
    logic                   w_f;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_det;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Shift the asynchronous line through the synchroniser chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
    end

`ifdef EDGE_DET_GLITCH_FILTER_EN
    localparam int FCW = (FILT_CYCLES < 2) ? 1 : $clog2(FILT_CYCLES + 1);

    logic           r_filt;
    logic [FCW-1:0] r_fcnt;

    // Accept a new level only once it has differed from the held level for FILT_CYCLES clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (w_s == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == FCW'(FILT_CYCLES - 1)) begin
            r_filt <= w_s;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    assign w_f = r_filt;
`else
    logic w_unused_filt;
    assign w_unused_filt = (FILT_CYCLES > 0);
    assign w_f           = w_s;
`endif

    assign w_rise = w_f & ~r_prev;
    assign w_fall = ~w_f & r_prev;
    assign w_det  = ((i_mode == EDGE_RISE || i_mode == EDGE_BOTH) & w_rise) |
                    ((i_mode == EDGE_FALL || i_mode == EDGE_BOTH) & w_fall);

    // Detect pulse, sticky flag and saturating count all update on the same edge; detect beats clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev   <= 1'b0;
            r_det    <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_prev   <= w_f;
            r_det    <= w_det;
            r_sticky <= w_det | (r_sticky & ~i_clr);
            if (i_clr)
                r_cnt <= w_det ? CNT_W'(1) : '0;
            else if (w_det && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_det    = r_det;
    assign o_sticky = r_sticky;
    assign o_cnt    = r_cnt;
endmodule

// File: rtl/multi_edge_det.sv
// rtl/multi_edge_det.sv - multi-channel edge detector top; optional filter macro EDGE_DET_GLITCH_FILTER_EN
module multi_edge_det
    import edge_det_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = 8,
    parameter int FILT_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    multi_edge_det_if.slave bus
);
    logic [NCH-1:0] w_det;

    // One independent channel per input line
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .FILT_CYCLES (FILT_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_sig    (bus.sig_i[g]),
            .i_mode   (edge_mode_e'(bus.mode_i[g])),
            .i_clr    (bus.clr_i[g]),
            .o_det    (w_det[g]),
            .o_sticky (bus.sticky_o[g]),
            .o_cnt    (bus.cnt_o[g])
        );
    end

    assign bus.det_o = w_det;
    assign bus.any_o = |w_det;
endmodule
